seq_match_ctrl: RTL and testbench

Run controller for serial pattern detection. Software loads a pattern, mask, match limit and bit window, then issues start. The block searches the gated serial stream for the masked pattern and counts matches, with overlapping matches allowed. It finishes on reaching the match limit or on window exhaustion, then reports done or timeout. It sits between the config/control register block and the serial receive front end.

---
 rtl/seq_match_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_seq_match_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_ctrl.sv
//-----------------------------------------------------------------------------
// seq_match_ctrl
//
// Run controller for serial pattern detection. A run is armed by a start
// pulse, which snapshots the configuration. The block then shifts accepted
// serial bits into a PAT_W-bit window and compares the masked window against
// the pattern after every accepted bit once the window is full. Matches are
// counted, and overlapping matches are allowed by default. A run ends when
// the match limit or the bit window is reached, with a single DONE cycle.
// An abort cancels the run without a done pulse.
//
// Optional build macro:
//   SEQ_MATCH_NOOVL_EN - non-overlapping mode. Each match clears the shift
//                        window and fill count, so the next match needs
//                        PAT_W fresh bits.
//
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous reset, active-low
//   cfg_pattern  in   [PAT_W] target pattern, MSB is the first-received bit
//   cfg_mask     in   [PAT_W] 1 = compare bit, 0 = don't care
//   cfg_limit    in   [CNT_W] matches to finish, 0 = unlimited
//   cfg_window   in   [WIN_W] accepted bits before timeout, 0 = none
//   start        in   begin run (accepted in IDLE only)
//   abort        in   cancel run
//   bit_valid    in   bit_in qualifier
//   bit_in       in   serial data
//   busy         out  run in progress (FILL, SEARCH, DONE)
//   match        out  1-cycle pulse per match
//   match_cnt    out  [CNT_W] matches in current/last run (saturating)
//   done         out  1-cycle run-complete pulse
//   timeout      out  last run ended by window exhaustion
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_match_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timeout
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_SEARCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PAT_W-1:0]   r_pat;
  logic [PAT_W-1:0]   r_mask;
  logic [CNT_W-1:0]   r_limit;
  logic [WIN_W-1:0]   r_window;

  logic [PAT_W-1:0]   r_shift;
  logic [FILL_W-1:0]  r_fill;
  logic [WIN_W-1:0]   r_win;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_match;
  logic               r_timeout;

  logic               w_accept;
  logic               w_start;
  logic [PAT_W-1:0]   w_shift_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic               w_cmp_en;
  logic               w_hit;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_lim_hit;
  logic [WIN_W-1:0]   w_win_inc;
  logic               w_win_hit;
  logic               w_finish;

  // Abort takes priority over both a start and a bit arriving in the same
  // cycle: the bit is dropped and the start is not taken.
  assign w_accept = bit_valid && !abort &&
                    ((r_state == S_FILL) || (r_state == S_SEARCH));
  assign w_start  = start && !abort && (r_state == S_IDLE);

  assign w_shift_nxt = {r_shift[PAT_W-2:0], bit_in};
  assign w_fill_nxt  = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;

  // Compare once the current bit completes a full window.
  assign w_cmp_en = (r_fill >= FILL_LAST);
  assign w_hit    = w_accept && w_cmp_en &&
                    (((w_shift_nxt ^ r_pat) & r_mask) == '0);

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_lim_hit = w_hit && (r_limit != '0) && (w_cnt_inc == r_limit);

  assign w_win_inc = r_win + 1'b1;
  assign w_win_hit = w_accept && (r_window != '0) && (w_win_inc == r_window);

  assign w_finish  = w_lim_hit || w_win_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_FILL;
      end
      S_FILL, S_SEARCH: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_finish) begin
          w_state_nxt = S_DONE;
        end else if (w_accept && w_cmp_en) begin
`ifdef SEQ_MATCH_NOOVL_EN
          w_state_nxt = w_hit ? S_FILL : S_SEARCH;
`else
          w_state_nxt = S_SEARCH;
`endif
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pat     <= '0;
      r_mask    <= '0;
      r_limit   <= '0;
      r_window  <= '0;
      r_shift   <= '0;
      r_fill    <= '0;
      r_win     <= '0;
      r_cnt     <= '0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_start) begin
        r_pat     <= cfg_pattern;
        r_mask    <= cfg_mask;
        r_limit   <= cfg_limit;
        r_window  <= cfg_window;
        r_shift   <= '0;
        r_fill    <= '0;
        r_win     <= '0;
        r_cnt     <= '0;
        r_timeout <= 1'b0;
      end else if (w_accept) begin
        r_win <= w_win_inc;
        if (w_hit) r_cnt <= w_cnt_inc;
        // Limit wins when both limits land on the same bit.
        if (w_finish) r_timeout <= !w_lim_hit;
`ifdef SEQ_MATCH_NOOVL_EN
        if (w_hit) begin
          r_shift <= '0;
          r_fill  <= '0;
        end else begin
          r_shift <= w_shift_nxt;
          r_fill  <= w_fill_nxt;
        end
`else
        r_shift <= w_shift_nxt;
        r_fill  <= w_fill_nxt;
`endif
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_seq_match_ctrl.sv
`timescale 1ns/1ps

module tb_seq_match_ctrl;

`ifdef SEQ_MATCH_NOOVL_EN
  localparam bit NOOVL = 1'b1;
`else
  localparam bit NOOVL = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  cfg_pattern;
  logic [7:0]  cfg_mask;
  logic [7:0]  cfg_limit;
  logic [15:0] cfg_window;
  logic        start;
  logic        abort;
  logic        bit_valid;
  logic        bit_in;
  logic        busy;
  logic        match;
  logic [7:0]  match_cnt;
  logic        done;
  logic        timeout;

  int n_err;
  int n_chk;

  seq_match_ctrl #(.PAT_W(8), .CNT_W(8), .WIN_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_limit   (cfg_limit),
    .cfg_window  (cfg_window),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .done        (done),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat;
    logic       bv;
    logic       bi;
    logic       st;
    logic       ab;
    logic       em;
    logic [7:0] ec;
    logic       eb;
    logic       ed;
    logic       et;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] pat, input logic bv, input logic bi,
                     input logic st, input logic ab, input logic em,
                     input logic [7:0] ec, input logic eb, input logic ed,
                     input logic et);
    vec_t v;
    v.pat = pat; v.bv = bv; v.bi = bi; v.st = st; v.ab = ab;
    v.em = em; v.ec = ec; v.eb = eb; v.ed = ed; v.et = et;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic bv, input logic bi, input logic st,
                     input logic ab);
    bit_valid = bv; bit_in = bi; start = st; abort = ab;
    @(posedge clk);
    #1;
    bit_valid = 1'b0; bit_in = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] pat, input logic [7:0] msk,
                         input logic [7:0] lim, input logic [15:0] win);
    cfg_pattern = pat; cfg_mask = msk; cfg_limit = lim; cfg_window = win;
  endtask

  initial begin
    logic [7:0] p;
    logic [9:0] b10;
    int         pulses;

    n_err = 0; n_chk = 0;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    set_cfg(8'h00, 8'hFF, 8'd0, 16'd0);

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    // Table: single match, then overlapping matches with live cfg changes
    // that must be ignored.
    p = 8'b01110001;
    add(p, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 7; i >= 1; i--) add(p, 1, p[i], 0, 0, 0, 0, 1, 0, 0);
    add(p, 1, p[0], 0, 0, 1, 1, 1, 0, 0);
    add(p, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(p, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    add(p, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    p = 8'b01010101;
    add(p, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 7; i >= 1; i--) add(8'h00, 1, p[i], 0, 0, 0, 0, 1, 0, 0);
    add(8'h00, 1, p[0], 0, 0, 1, 1, 1, 0, 0);
    add(8'h00, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(8'h00, 1, 1, 0, 0, !NOOVL, NOOVL ? 8'd1 : 8'd2, 1, 0, 0);
    add(8'h00, 0, 0, 0, 1, 0, NOOVL ? 8'd1 : 8'd2, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cfg_pattern = tbl[i].pat;
      cyc(tbl[i].bv, tbl[i].bi, tbl[i].st, tbl[i].ab);
      chk($sformatf("vec%0d_match", i), match, tbl[i].em);
      chk($sformatf("vec%0d_cnt", i), match_cnt, tbl[i].ec);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("vec%0d_done", i), done, tbl[i].ed);
      chk($sformatf("vec%0d_timeout", i), timeout, tbl[i].et);
    end

    // Limit=2 with random bit_valid gaps: second match coincides with done.
    p = 8'b01110001;
    set_cfg(p, 8'hFF, 8'd2, 16'd0);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cyc(0, 1, 0, 0);
        chk("t3_gap_match", match, 0);
      end
      cyc(1, p[7 - (k % 8)], 0, 0);
      if (k < 15) begin
        chk("t3_match", match, (k == 7) ? 1 : 0);
        chk("t3_done", done, 0);
      end
    end
    chk("t3_last_match", match, 1);
    chk("t3_last_done", done, 1);
    chk("t3_cnt", match_cnt, 2);
    chk("t3_timeout", timeout, 0);
    chk("t3_busy", busy, 1);
    cyc(0, 0, 0, 0);
    chk("t3_after_busy", busy, 0);
    chk("t3_after_done", done, 0);

    // Window=10 exhaustion, then limit and window on the same bit.
    set_cfg(p, 8'hFF, 8'd1, 16'd10);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 9; k++) cyc(1, 1, 0, 0);
    chk("t4_pre_done", done, 0);
    cyc(1, 1, 0, 0);
    chk("t4_done", done, 1);
    chk("t4_timeout", timeout, 1);
    chk("t4_cnt", match_cnt, 0);
    cyc(0, 0, 0, 0);
    chk("t4_idle_busy", busy, 0);
    chk("t4_timeout_hold", timeout, 1);
    cyc(0, 0, 1, 0);
    chk("t4_start_clr_timeout", timeout, 0);
    b10 = 10'b1101110001;
    for (int k = 9; k >= 1; k--) cyc(1, b10[k], 0, 0);
    chk("t4b_pre_match", match, 0);
    cyc(1, b10[0], 0, 0);
    chk("t4b_match", match, 1);
    chk("t4b_done", done, 1);
    chk("t4b_timeout", timeout, 0);
    chk("t4b_cnt", match_cnt, 1);
    cyc(0, 0, 0, 0);

    // Abort in FILL, fresh run must not reuse old bits; start mid-run ignored.
    set_cfg(p, 8'hFF, 8'd0, 16'd0);
    cyc(0, 0, 1, 0);
    for (int i = 7; i >= 4; i--) cyc(1, p[i], 0, 0);
    cyc(0, 0, 0, 1);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    cyc(0, 0, 1, 0);
    pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      cyc(1, p[i], 0, 0);
      pulses += int'(match);
    end
    for (int i = 7; i >= 0; i--) begin
      if (i == 5) cyc(0, 0, 1, 0);
      cyc(1, p[i], 0, 0);
      pulses += int'(match);
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_last_match", match, 1);
    chk("t5_cnt", match_cnt, 1);
    chk("t5_busy", busy, 1);
    cyc(0, 0, 0, 1);

    // mask=0: every bit from the 8th matches; then counter saturation.
    set_cfg(8'h5A, 8'h00, 8'd0, 16'd0);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 7; k++) cyc(1, k[0], 0, 0);
    chk("t7_bit7_match", match, 0);
    cyc(1, 0, 0, 0);
    chk("t7_bit8_match", match, 1);
    cyc(1, 1, 0, 0);
    chk("t7_bit9_match", match, !NOOVL);
    chk("t7_cnt", match_cnt, NOOVL ? 1 : 2);
    for (int k = 0; k < 2100; k++) cyc(1, 1, 0, 0);
    chk("t7_sat_cnt", match_cnt, 255);
    cyc(0, 0, 0, 1);

    // Partial mask, then reset in the middle of a search.
    set_cfg(8'hA1, 8'h0F, 8'd0, 16'd0);
    cyc(0, 0, 1, 0);
    p = 8'b11110001;
    for (int i = 7; i >= 0; i--) cyc(1, p[i], 0, 0);
    chk("t6_match", match, 1);
    chk("t6_cnt", match_cnt, 1);
    cyc(1, 0, 0, 0);
    chk("t6_nomatch", match, 0);
    rst_n = 1'b0;
    cyc(1, 1, 0, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cnt", match_cnt, 0);
    chk("t6_rst_match", match, 0);
    chk("t6_rst_done", done, 0);
    rst_n = 1'b1;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_match", match, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
